// File: rtl/bp_pkg.sv
// Shared types and constants for the IF-stage branch predictor.
// Holds the BTB entry layout, the predict bundle and the counter encodings.
package bp_pkg;

    localparam int BTB_IDX_W = 4;
    localparam int BHR_W     = 4;
    localparam int BTB_N     = 1 << BTB_IDX_W;
    localparam int GBC_N     = 1 << BHR_W;
    localparam int TAG_W     = 32 - BTB_IDX_W - 2;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             is_jal;
    } btb_entry_t;

    // Rides down IF/ID and ID/EX alongside the instruction.
    typedef struct packed {
        logic             b_hit;
        logic             j_hit;
        logic             predict_taken;
        logic [BHR_W-1:0] bhr;
    } pred_bundle_t;

    function automatic cnt_e cnt_update(input cnt_e cnt, input logic taken);
        cnt_e nxt;
        case (cnt)
            CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
            default: nxt = CNT_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Gshare global branch counter table: combinational indexed read,
// single-port saturating 2-bit update on the clock edge.
module bp_sat_counter_table
    import bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BHR_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [BHR_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    cnt_e cnt_q [GBC_N];
    cnt_e cnt_d;

    assign rd_cnt_o = cnt_q[rd_idx_i];

    // Next value of the counter addressed by the resolving branch.
    always_comb begin
        cnt_d = cnt_update(cnt_q[wr_idx_i], wr_taken_i);
    end

    // Counter storage; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GBC_N; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB, gshare counters and a
// speculative history register, with EX-side resolution and redirect.
module branch_predictor
    import bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic             if_stall,
    output logic             pred_btb_b_hit,
    output logic             pred_btb_j_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [BHR_W-1:0] pred_bhr,
    output logic             pred_redirect,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_btb_b_hit,
    input  logic             ex_btb_j_hit,
    input  logic             ex_gbc_predict_taken,
    input  logic [BHR_W-1:0] ex_bhr,
    output logic             ex_mispredict,
    output logic [31:0]      ex_redirect_pc
);

    btb_entry_t       btb_q [BTB_N];
    btb_entry_t       if_entry_s;
    btb_entry_t       btb_wr_s;
    logic [BHR_W-1:0] bhr_q, bhr_d;
    logic [1:0]       gbc_cnt_s;
    pred_bundle_t     pred_s;
    logic             br_res_s, jal_res_s, mis_s, alloc_s;
    logic             if_pc_unused_s;

    assign if_pc_unused_s = ^if_pc[1:0];
    assign if_entry_s     = btb_q[if_pc[BTB_IDX_W+1:2]];

    bp_sat_counter_table u_gbc (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (if_pc[BHR_W+1:2] ^ bhr_q),
        .rd_cnt_o   (gbc_cnt_s),
        .wr_en_i    (br_res_s),
        .wr_idx_i   (ex_pc[BHR_W+1:2] ^ ex_bhr),
        .wr_taken_i (ex_taken)
    );

    // Fetch-side lookup forming the predict bundle.
    always_comb begin
        pred_s = '0;
        if (if_entry_s.valid && (if_entry_s.tag == if_pc[31:BTB_IDX_W+2])) begin
            pred_s.b_hit         = ~if_entry_s.is_jal;
            pred_s.j_hit         = if_entry_s.is_jal;
            pred_s.predict_taken = ~if_entry_s.is_jal & gbc_cnt_s[1];
        end else begin
            pred_s.b_hit         = 1'b0;
        end
        pred_s.bhr = bhr_q;
    end

    assign pred_btb_b_hit = pred_s.b_hit;
    assign pred_btb_j_hit = pred_s.j_hit;
    assign pred_taken     = pred_s.predict_taken;
    assign pred_target    = if_entry_s.target;
    assign pred_bhr       = pred_s.bhr;
    assign pred_redirect  = (pred_s.b_hit & pred_s.predict_taken) | pred_s.j_hit;

    // EX resolution; a branch flag wins if both op flags are ever set.
    always_comb begin
        br_res_s  = ex_valid & ex_is_branch;
        jal_res_s = ex_valid & ~ex_is_branch & ex_is_jal;
        mis_s     = 1'b0;
        ex_redirect_pc = 32'd0;
        if (br_res_s) begin
            mis_s = (ex_btb_b_hit & ex_gbc_predict_taken) != ex_taken;
        end else if (jal_res_s) begin
            mis_s = ~ex_btb_j_hit;
        end else begin
            mis_s = 1'b0;
        end
        if (br_res_s || jal_res_s) begin
            ex_redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
        end else begin
            ex_redirect_pc = 32'd0;
        end
        alloc_s  = ex_taken & ((br_res_s & ~ex_btb_b_hit) | (jal_res_s & ~ex_btb_j_hit));
        btb_wr_s = '{valid: 1'b1, tag: ex_pc[31:BTB_IDX_W+2],
                     target: ex_target, is_jal: jal_res_s};
    end

    assign ex_mispredict = mis_s;

    // History next state: EX recovery beats the speculative fetch shift.
    always_comb begin
        bhr_d = bhr_q;
        if (br_res_s && mis_s) begin
            bhr_d = {ex_bhr[BHR_W-2:0], ex_taken};
        end else if (pred_s.b_hit && !if_stall) begin
            bhr_d = {bhr_q[BHR_W-2:0], pred_s.predict_taken};
        end else begin
            bhr_d = bhr_q;
        end
    end

    // History register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bhr_q <= '0;
        end else begin
            bhr_q <= bhr_d;
        end
    end

    // BTB storage; allocation only for taken ops the bundle says missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_q[i] <= '0;
            end
        end else if (alloc_s) begin
            btb_q[ex_pc[BTB_IDX_W+1:2]] <= btb_wr_s;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
module tb_branch_predictor;

    localparam int S_BHIT = 0, S_JHIT = 1, S_PT = 2, S_TGT = 3,
                   S_BHR = 4, S_PRED = 5, S_MIS = 6, S_RPC = 7;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        pred_btb_b_hit, pred_btb_j_hit, pred_taken, pred_redirect;
    logic [31:0] pred_target;
    logic [3:0]  pred_bhr;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_taken;
    logic [31:0] ex_pc, ex_target;
    logic        ex_btb_b_hit, ex_btb_j_hit, ex_gbc_predict_taken;
    logic [3:0]  ex_bhr;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_stall(if_stall),
        .pred_btb_b_hit(pred_btb_b_hit), .pred_btb_j_hit(pred_btb_j_hit),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_bhr(pred_bhr),
        .pred_redirect(pred_redirect), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_btb_b_hit(ex_btb_b_hit),
        .ex_btb_j_hit(ex_btb_j_hit), .ex_gbc_predict_taken(ex_gbc_predict_taken),
        .ex_bhr(ex_bhr), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc)
    );

    function automatic logic [31:0] obs_of(input int sig);
        case (sig)
            S_BHIT:  return {31'd0, pred_btb_b_hit};
            S_JHIT:  return {31'd0, pred_btb_j_hit};
            S_PT:    return {31'd0, pred_taken};
            S_TGT:   return pred_target;
            S_BHR:   return {28'd0, pred_bhr};
            S_PRED:  return {31'd0, pred_redirect};
            S_MIS:   return {31'd0, ex_mispredict};
            S_RPC:   return ex_redirect_pc;
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_of(e.sig);
            tests_run++;
            assert (o === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic jal,
                            input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic bh, input logic jh, input logic pt, input logic [3:0] bhr);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_btb_b_hit = bh; ex_btb_j_hit = jh;
        ex_gbc_predict_taken = pt; ex_bhr = bhr;
    endtask

    task automatic ex_idle();
        ex_drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'h100; if_stall = 1'b0;
        ex_idle();
        // Reset state
        expect_val("rst_bhit", S_BHIT, 32'd0);
        expect_val("rst_jhit", S_JHIT, 32'd0);
        expect_val("rst_pt",   S_PT,   32'd0);
        expect_val("rst_bhr",  S_BHR,  32'd0);
        expect_val("rst_tgt",  S_TGT,  32'd0);
        expect_val("rst_pred", S_PRED, 32'd0);
        expect_val("rst_mis",  S_MIS,  32'd0);
        expect_val("rst_rpc",  S_RPC,  32'd0);
        settle();
        rst_n = 1'b1;

        // JAL first execution: miss -> mispredict, allocate
        ex_drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_val("jal1_mis", S_MIS, 32'd1);
        expect_val("jal1_rpc", S_RPC, 32'h80);
        settle();

        // JAL lookup hits; EX JAL with j_hit is not a mispredict
        if_pc = 32'h40;
        ex_drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_val("jal2_jhit", S_JHIT, 32'd1);
        expect_val("jal2_bhit", S_BHIT, 32'd0);
        expect_val("jal2_tgt",  S_TGT,  32'h80);
        expect_val("jal2_pred", S_PRED, 32'd1);
        expect_val("jal2_mis",  S_MIS,  32'd0);
        expect_val("jal2_rpc",  S_RPC,  32'h80);
        settle();

        // Train branch 0x20 -> 0x10 three times with bhr=0
        if_pc = 32'h100;
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_val("br1_mis", S_MIS, 32'd1);
        expect_val("br1_rpc", S_RPC, 32'h10);
        settle();
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 4'd0);
        expect_val("br2_mis", S_MIS, 32'd0);
        expect_val("br2_bhr", S_BHR, 32'h1);
        settle();
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 4'd0);
        expect_val("br3_mis", S_MIS, 32'd0);
        settle();

        // Not-taken mispredict at 0x64 restores BHR to 0
        ex_drive(1'b1, 1'b1, 1'b0, 32'h64, 1'b0, 32'h99, 1'b1, 1'b0, 1'b1, 4'd0);
        expect_val("nt_mis", S_MIS, 32'd1);
        expect_val("nt_rpc", S_RPC, 32'h68);
        expect_val("nt_bhr", S_BHR, 32'h1);
        settle();

        // Lookup trained branch: strongly taken, speculative shift follows
        ex_idle();
        if_pc = 32'h20;
        expect_val("lk_bhit", S_BHIT, 32'd1);
        expect_val("lk_jhit", S_JHIT, 32'd0);
        expect_val("lk_pt",   S_PT,   32'd1);
        expect_val("lk_tgt",  S_TGT,  32'h10);
        expect_val("lk_pred", S_PRED, 32'd1);
        expect_val("lk_bhr",  S_BHR,  32'd0);
        settle();
        if_pc = 32'h64;
        expect_val("noalloc_bhit", S_BHIT, 32'd0);
        expect_val("spec_bhr",     S_BHR,  32'h1);
        settle();

        // One not-taken after saturation must leave counter at WT
        if_pc = 32'h100;
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 4'd0);
        expect_val("sat_mis", S_MIS, 32'd1);
        expect_val("sat_rpc", S_RPC, 32'h24);
        settle();
        ex_idle();
        if_pc = 32'h20; if_stall = 1'b1;
        expect_val("sat_pt",   S_PT,   32'd1);
        expect_val("sat_bhit", S_BHIT, 32'd1);
        expect_val("sat_bhr",  S_BHR,  32'd0);
        settle();

        // Recovery vs concurrent speculative update
        if_stall = 1'b0;
        ex_drive(1'b1, 1'b1, 1'b0, 32'h24, 1'b0, 32'h99, 1'b1, 1'b0, 1'b1, 4'b0101);
        expect_val("rec_mis",   S_MIS, 32'd1);
        expect_val("rec_rpc",   S_RPC, 32'h28);
        expect_val("stall_bhr", S_BHR, 32'd0);
        settle();

        // Bubble with is_branch set
        if_pc = 32'h100;
        ex_drive(1'b0, 1'b1, 1'b0, 32'h60, 1'b1, 32'h70, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_val("rec_bhr",  S_BHR, 32'ha);
        expect_val("bub_mis",  S_MIS, 32'd0);
        expect_val("bub_rpc",  S_RPC, 32'd0);
        settle();
        ex_idle();
        if_pc = 32'h60;
        expect_val("bub_bhit", S_BHIT, 32'd0);
        expect_val("bub_bhr",  S_BHR,  32'ha);
        settle();

        // Mid-stream reset, asserted between clock edges
        if_pc = 32'h20;
        expect_val("pre_bhit", S_BHIT, 32'd1);
        expect_val("pre_pt",   S_PT,   32'd0);
        @(negedge clk);
        drain();
        #1 rst_n = 1'b0;
        #1;
        expect_val("mrst_bhit", S_BHIT, 32'd0);
        expect_val("mrst_bhr",  S_BHR,  32'd0);
        expect_val("mrst_tgt",  S_TGT,  32'd0);
        expect_val("mrst_pred", S_PRED, 32'd0);
        drain();
        if_pc = 32'h40;
        #1;
        expect_val("mrst_jhit", S_JHIT, 32'd0);
        drain();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Counters back at WNT: one taken then one not-taken -> predict NT
        if_pc = 32'h100;
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 4'd0);
        settle();
        ex_idle();
        if_pc = 32'h20; if_stall = 1'b1;
        expect_val("post_bhit", S_BHIT, 32'd1);
        expect_val("post_pt",   S_PT,   32'd0);
        expect_val("post_bhr",  S_BHR,  32'd0);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor: BTB plus gshare global branch counters (GBC) plus a speculative branch history register (BHR).
- Produces the per-instruction prediction bundle that rides down the pipeline: b_hit, j_hit, predict_taken, bhr.
- Consumes the same bundle when it returns from EX with the resolved outcome. Updates its tables, detects mispredicts and drives the fetch redirect.

Parameters:
- BTB_IDX_W, 4, log2 of BTB entry count (16 entries, direct-mapped).
- BHR_W, 4, history length; GBC has 2^BHR_W 2-bit counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  current fetch PC
- if_stall  in  1  fetch held this cycle
- pred_btb_b_hit  out  1  BTB hit, conditional-branch entry
- pred_btb_j_hit  out  1  BTB hit, JAL entry
- pred_taken  out  1  GBC counter MSB
- pred_target  out  32  BTB target
- pred_bhr  out  BHR_W  BHR snapshot before this fetch's update
- pred_redirect  out  1  b_hit&pred_taken | j_hit
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  32  EX PC
- ex_is_branch  in  1  conditional branch in EX
- ex_is_jal  in  1  JAL in EX
- ex_taken  in  1  resolved direction (1 for JAL)
- ex_target  in  32  resolved taken target
- ex_btb_b_hit  in  1  returned bundle
- ex_btb_j_hit  in  1  returned bundle
- ex_gbc_predict_taken  in  1  returned bundle
- ex_bhr  in  BHR_W  returned bundle
- ex_mispredict  out  1  flush IF/ID and ID/EX
- ex_redirect_pc  out  32  correct next PC

Behaviour:
- Reset (async, rst_n=0):
  - All BTB valid bits 0.
  - All GBC counters 2'b01 (weakly not-taken).
  - BHR 0.
  - Consequently all pred_* outputs are 0, ex_mispredict=0, ex_redirect_pc=0.
  - Reset asserted mid-operation discards all state immediately.
- BTB entry fields: valid, tag=pc[31:BTB_IDX_W+2], target[31:0], type (0 branch, 1 JAL).
- BTB index: pc[BTB_IDX_W+1:2].
- Lookup is combinational from if_pc and registered state:
  - hit = valid & tag match; b_hit = hit&~type; j_hit = hit&type.
  - GBC index = if_pc[BHR_W+1:2] ^ BHR.
  - pred_taken = counter[1] when b_hit, else 0.
  - pred_target = entry target.
  - pred_bhr = current BHR.
- Speculative BHR update: on posedge with b_hit & ~if_stall, BHR <= {BHR[BHR_W-2:0], pred_taken}.
- Resolution (combinational), only when ex_valid & (ex_is_branch|ex_is_jal):
  - Branch: ex_mispredict = (ex_btb_b_hit&ex_gbc_predict_taken) != ex_taken.
  - JAL: ex_mispredict = ~ex_btb_j_hit.
  - ex_redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - JALR is not predicted; it never asserts ex_mispredict here.
  - Bubbles (ex_valid=0 or op is NOP) produce ex_mispredict=0.
- Table updates at posedge for a valid resolved instruction:
  - GBC: for branches only, counter at ex_pc[BHR_W+1:2]^ex_bhr saturates up if taken, down if not. 11 stays 11; 00 stays 00.
  - BTB: allocate/overwrite on a taken branch or JAL whose bundle hit bit is 0. Write valid=1, tag, target=ex_target, type.
  - Not-taken branches never allocate.
- BHR recovery on a branch mispredict: BHR <= {ex_bhr[BHR_W-2:0], ex_taken}.
  - Recovery has priority over the same-cycle speculative IF update.
- JAL mispredict does not touch BHR.
- Same-cycle read and write of one BTB/GBC entry: lookup returns the pre-write value; the new value is visible next cycle.

Decomposition:
- Shared package bp_pkg: BTB_IDX_W, BHR_W, counter encodings (SNT=00, WNT=01, WT=10, ST=11), btb_entry_t struct, and the predict bundle struct {b_hit, j_hit, predict_taken, bhr} reused by the IF/ID and ID/EX registers.
- One natural sub-module: bp_sat_counter_table (GBC array with indexed read and saturating update).

Test Plan:
- Reset → lookup at if_pc=0x100 gives b_hit=0, j_hit=0, pred_taken=0, pred_bhr=0; GBC counters read 01.
- JAL at 0x40 to 0x80, first execution (j_hit=0) → ex_mispredict=1, redirect=0x80. Next fetch of 0x40 gives j_hit=1, pred_target=0x80, pred_redirect=1.
- Taken branch at 0x20 → 0x10 resolved 3 times with bhr=0 → counter goes 01→10→11→11 (saturates). After allocation, lookup gives b_hit=1, pred_taken=1.
- Branch predicted taken (b_hit=1, predict_taken=1, ex_bhr=4'b0101) resolves not-taken → ex_mispredict=1, redirect=ex_pc+4, BHR=4'b1010 next cycle, even with a concurrent speculative IF update.
- Bubble with ex_valid=0 and ex_is_branch=1 → no mispredict and no table or BHR change.
- Assert rst_n low mid-stream after training → all BTB valid bits clear, BHR=0, counters 01, within the same cycle.
